// File: rtl/fir_pkg.sv
// Shared definitions for the transposed-form FIR.
//   - Default widths and tap count used by fir_transposed_stream.
//   - DEFAULT_COEF: coefficient bank loaded on reset (symmetric low-pass).
//   - round_sat(): round-half-up, arithmetic right shift, clip to XW bits.
package fir_pkg;

    localparam int unsigned FIR_NTAPS = 11;
    localparam int unsigned FIR_XW    = 16;
    localparam int unsigned FIR_CW    = 16;
    localparam int unsigned FIR_ACCW  = 36;
    localparam int unsigned FIR_SHIFT = 16;

    localparam logic signed [FIR_CW-1:0] DEFAULT_COEF [FIR_NTAPS] = '{
        -16'sd136, -16'sd397, -16'sd87, 16'sd3004, 16'sd8338, 16'sd11142,
        16'sd8338, 16'sd3004, -16'sd87, -16'sd397, -16'sd136
    };

    // One bit of headroom so the rounding constant cannot wrap a full-scale sum.
    localparam logic signed [FIR_ACCW:0] Y_MAX = (FIR_ACCW+1)'((1 << (FIR_XW - 1)) - 1);
    localparam logic signed [FIR_ACCW:0] Y_MIN = ~Y_MAX;

    typedef struct packed {
        logic signed [FIR_XW-1:0] y;
        logic                     sat;
    } rnd_t;

    // Taps beyond the default table start at zero.
    function automatic logic signed [FIR_CW-1:0] default_coef(input int unsigned k);
        if (k < FIR_NTAPS) begin
            return DEFAULT_COEF[k[3:0]];
        end
        return '0;
    endfunction

    function automatic rnd_t round_sat(input logic signed [FIR_ACCW-1:0] sum,
                                       input int unsigned               shift);
        logic signed [FIR_ACCW:0] w_half;
        logic signed [FIR_ACCW:0] w_biased;
        logic signed [FIR_ACCW:0] w_r;
        rnd_t                     res;
        w_half   = (FIR_ACCW+1)'(1) << (shift - 1);
        w_biased = {sum[FIR_ACCW-1], sum} + w_half;
        w_r      = w_biased >>> shift;
        if (w_r > Y_MAX) begin
            res.y   = Y_MAX[FIR_XW-1:0];
            res.sat = 1'b1;
        end else if (w_r < Y_MIN) begin
            res.y   = Y_MIN[FIR_XW-1:0];
            res.sat = 1'b1;
        end else begin
            res.y   = w_r[FIR_XW-1:0];
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_tstage.sv
// One transposed-form tap: multiplies the broadcast sample by its coefficient,
// adds the upstream partial sum and registers the result when a sample is valid.
//   clk, reset_p : clock, synchronous active-high reset
//   i_clr        : synchronous clear of the partial sum (flush)
//   i_en         : a valid sample is in stage 2
//   i_x, i_coef  : broadcast sample and this tap's coefficient
//   i_sum        : partial sum from the upstream (higher-index) tap
//   o_sum        : registered partial sum toward the output
module fir_tstage
    import fir_pkg::*;
#(
    parameter int unsigned XW   = FIR_XW,
    parameter int unsigned CW   = FIR_CW,
    parameter int unsigned ACCW = FIR_ACCW
) (
    input  logic                   clk,
    input  logic                   reset_p,
    input  logic                   i_clr,
    input  logic                   i_en,
    input  logic signed [XW-1:0]   i_x,
    input  logic signed [CW-1:0]   i_coef,
    input  logic signed [ACCW-1:0] i_sum,
    output logic signed [ACCW-1:0] o_sum
);

    logic signed [XW+CW-1:0] w_prod;
    logic signed [ACCW-1:0]  w_prod_ext;
    logic signed [ACCW-1:0]  r_sum;

    assign w_prod     = i_coef * i_x;
    assign w_prod_ext = {{(ACCW-XW-CW){w_prod[XW+CW-1]}}, w_prod};

    // Holds on idle cycles so gaps in the stream insert no zeros.
    always_ff @(posedge clk) begin
        if (reset_p || i_clr) begin
            r_sum <= '0;
        end else if (i_en) begin
            r_sum <= i_sum + w_prod_ext;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/fir_transposed_stream.sv
// Transposed-form signed FIR with sample-valid handshake and runtime coefficients.
// Fixed 2-cycle latency from i_in_valid to o_out_valid regardless of tap count.
//   clk, reset_p           : clock, synchronous active-high reset (restores coefficients)
//   i_in_valid, i_x        : input sample and its valid strobe
//   i_flush                : clear delay line and primed count, keep coefficients
//   i_coef_we/addr/data    : coefficient write port (addresses >= NTAPS ignored)
//   o_out_valid, o_y, o_sat: one-cycle result pulse, rounded/saturated output, clip flag
//   o_primed               : NTAPS samples accepted since reset or flush
// Rounding/saturation widths come from fir_pkg; XW and ACCW must match FIR_XW/FIR_ACCW.
module fir_transposed_stream
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS = FIR_NTAPS,
    parameter int unsigned XW    = FIR_XW,
    parameter int unsigned CW    = FIR_CW,
    parameter int unsigned ACCW  = FIR_ACCW,
    parameter int unsigned SHIFT = FIR_SHIFT
) (
    input  logic                 clk,
    input  logic                 reset_p,
    input  logic                 i_in_valid,
    input  logic signed [XW-1:0] i_x,
    input  logic                 i_flush,
    input  logic                 i_coef_we,
    input  logic [3:0]           i_coef_addr,
    input  logic signed [CW-1:0] i_coef_data,
    output logic                 o_out_valid,
    output logic signed [XW-1:0] o_y,
    output logic                 o_sat,
    output logic                 o_primed
);

    localparam int unsigned CNTW = $clog2(NTAPS + 1);

    logic signed [XW-1:0]    r_x;
    logic                    r_v;
    logic [CNTW-1:0]         r_count;
    logic                    r_out_valid;
    logic signed [XW-1:0]    r_y;
    logic                    r_sat;

    logic signed [CW-1:0]    w_coef [NTAPS];
    logic signed [ACCW-1:0]  w_s [1:NTAPS];
    logic signed [XW+CW-1:0] w_prod0;
    logic signed [ACCW-1:0]  w_sum0;
    rnd_t                    w_rnd;

    // Coefficient bank: a write is seen by stage 2 from the next cycle on, so a
    // sample in stage 2 during the write still uses the old value.
    for (genvar k = 0; k < NTAPS; k++) begin : g_coef
        logic signed [CW-1:0] r_c;
        always_ff @(posedge clk) begin
            if (reset_p) begin
                r_c <= default_coef(k);
            end else if (i_coef_we && (i_coef_addr == 4'(k))) begin
                r_c <= i_coef_data;
            end
        end
        assign w_coef[k] = r_c;
    end

    // The farthest tap has no upstream sum.
    assign w_s[NTAPS] = '0;

    for (genvar k = 1; k < NTAPS; k++) begin : g_tap
        fir_tstage #(
            .XW   (XW),
            .CW   (CW),
            .ACCW (ACCW)
        ) u_tap (
            .clk     (clk),
            .reset_p (reset_p),
            .i_clr   (i_flush),
            .i_en    (r_v),
            .i_x     (r_x),
            .i_coef  (w_coef[k]),
            .i_sum   (w_s[k+1]),
            .o_sum   (w_s[k])
        );
    end

    // Tap 0 is the output adder.
    assign w_prod0 = w_coef[0] * r_x;
    assign w_sum0  = w_s[1] + {{(ACCW-XW-CW){w_prod0[XW+CW-1]}}, w_prod0};
    assign w_rnd   = round_sat(w_sum0, SHIFT);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_x         <= '0;
            r_v         <= 1'b0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_sat       <= 1'b0;
        end else if (i_flush) begin
            // Drops both a simultaneous input and the sample in stage 2; y/sat hold.
            r_x         <= '0;
            r_v         <= 1'b0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_v;
            if (r_v) begin
                r_y   <= w_rnd.y;
                r_sat <= w_rnd.sat;
            end
            if (i_in_valid) begin
                r_x <= i_x;
                r_v <= 1'b1;
                if (r_count < CNTW'(NTAPS)) begin
                    r_count <= r_count + 1'b1;
                end
            end else begin
                r_v <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_y         = r_y;
    assign o_sat       = r_sat;
    assign o_primed    = (r_count >= CNTW'(NTAPS));

endmodule

// File: tb/tb_fir_transposed_stream.sv
module tb_fir_transposed_stream;

    localparam int NTAPS = 11;

    typedef int coefv_t [NTAPS];
    typedef struct {
        logic signed [15:0] y;
        logic               sat;
        int                 cyc;
    } exp_t;

    localparam coefv_t DEF = '{-136, -397, -87, 3004, 8338, 11142, 8338, 3004, -87, -397, -136};
    localparam int IMP [12] = '{-68, -198, -43, 1502, 4169, 5571, 4169, 1502, -43, -198, -68, 0};

    logic               clk = 1'b0;
    logic               reset_p = 1'b1;
    logic               i_in_valid = 1'b0;
    logic signed [15:0] i_x = '0;
    logic               i_flush = 1'b0;
    logic               i_coef_we = 1'b0;
    logic [3:0]         i_coef_addr = '0;
    logic signed [15:0] i_coef_data = '0;
    logic               o_out_valid;
    logic signed [15:0] o_y;
    logic               o_sat;
    logic               o_primed;

    fir_transposed_stream u_dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .i_in_valid  (i_in_valid),
        .i_x         (i_x),
        .i_flush     (i_flush),
        .i_coef_we   (i_coef_we),
        .i_coef_addr (i_coef_addr),
        .i_coef_data (i_coef_data),
        .o_out_valid (o_out_valid),
        .o_y         (o_y),
        .o_sat       (o_sat),
        .o_primed    (o_primed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t               exp_q [$];
    int                 hx [$];
    coefv_t             hc [$];
    coefv_t             mcoef = DEF;
    logic signed [15:0] obs_y [$];
    logic               obs_s [$];
    int                 obs_c [$];
    exp_t               e_mon;

    // Reference: y(n) = sum_k c_(n-k)[k] * x(n-k), where c_m is the coefficient
    // set in force when sample m was multiplied.
    task automatic model_accept(input int xv);
        longint acc = 0;
        longint r;
        exp_t   e;
        hx.push_front(xv);
        hc.push_front(mcoef);
        if (hx.size() > NTAPS) begin
            void'(hx.pop_back());
            void'(hc.pop_back());
        end
        for (int k = 0; k < hx.size(); k++) begin
            acc += longint'(hc[k][k]) * longint'(hx[k]);
        end
        r = (acc + 64'sd32768) >>> 16;
        if (r > 32767) begin
            e.y = 16'sd32767; e.sat = 1'b1;
        end else if (r < -32768) begin
            e.y = -16'sd32768; e.sat = 1'b1;
        end else begin
            e.y = 16'(r); e.sat = 1'b0;
        end
        e.cyc = cyc + 2;
        exp_q.push_back(e);
    endtask

    task automatic model_clear();
        hx.delete();
        hc.delete();
    endtask

    // Scoreboard: every pulse must match the oldest expectation, on time.
    always @(posedge clk) begin
        #1;
        if (o_out_valid) begin
            obs_y.push_back(o_y);
            obs_s.push_back(o_sat);
            obs_c.push_back(cyc);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra_pulse: got y=%0d at cycle %0d, required no pulse", o_y, cyc);
            end else begin
                e_mon = exp_q.pop_front();
                if (o_y !== e_mon.y || o_sat !== e_mon.sat || cyc != e_mon.cyc) begin
                    n_fail++;
                    $display("FAIL sb_result: got y=%0d sat=%0b cyc=%0d, required y=%0d sat=%0b cyc=%0d",
                             o_y, o_sat, cyc, e_mon.y, e_mon.sat, e_mon.cyc);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e_mon = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL sb_missing_pulse: got no pulse at cycle %0d, required y=%0d", cyc, e_mon.y);
        end
    end

    task automatic sample(input int xv, input bit push = 1'b1);
        @(negedge clk);
        i_in_valid = 1'b1;
        i_x        = 16'(xv);
        if (push) model_accept(xv);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_in_valid = 1'b0;
        end
    endtask

    task automatic write_coef(input int addr, input int data);
        @(negedge clk);
        i_in_valid  = 1'b0;
        i_coef_we   = 1'b1;
        i_coef_addr = 4'(addr);
        i_coef_data = 16'(data);
        @(posedge clk);
        #1;
        i_coef_we = 1'b0;
        if (addr < NTAPS) mcoef[addr] = data;
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
            exp_q.delete();
        end
        idle(2);
    endtask

    task automatic clear_obs();
        obs_y.delete();
        obs_s.delete();
        obs_c.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_p    = 1'b1;
        i_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_p = 1'b0;
        mcoef   = DEF;
        model_clear();
        exp_q.delete();
    endtask

    task automatic check_impulse(input string name);
        clear_obs();
        sample(32767);
        repeat (11) sample(0);
        drain();
        n_tests++;
        if (obs_y.size() != 12) begin
            n_fail++;
            $display("FAIL %s_count: got %0d outputs, required 12", name, obs_y.size());
        end
        for (int i = 0; i < 12 && i < obs_y.size(); i++) begin
            n_tests++;
            if (obs_y[i] !== 16'(IMP[i]) || obs_s[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_y%0d: got y=%0d sat=%0b, required y=%0d sat=0",
                         name, i, obs_y[i], obs_s[i], IMP[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset_p = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (o_out_valid !== 1'b0 || o_y !== 16'sd0 || o_sat !== 1'b0 || o_primed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%0b y=%0d sat=%0b primed=%0b, required all 0",
                     o_out_valid, o_y, o_sat, o_primed);
        end
        reset_p = 1'b0;
    endtask

    task automatic test_impulse();
        check_impulse("impulse");
        n_tests++;
        if (o_primed !== 1'b1) begin
            n_fail++;
            $display("FAIL impulse_primed: got %0b, required 1", o_primed);
        end
    endtask

    task automatic test_gapped();
        clear_obs();
        sample(32767);
        idle(2);
        for (int i = 0; i < 11; i++) begin
            sample(0);
            idle(2);
        end
        drain();
        for (int i = 0; i < 12 && i < obs_y.size(); i++) begin
            n_tests++;
            if (obs_y[i] !== 16'(IMP[i])) begin
                n_fail++;
                $display("FAIL gapped_y%0d: got %0d, required %0d", i, obs_y[i], IMP[i]);
            end
        end
        for (int i = 1; i < obs_c.size(); i++) begin
            n_tests++;
            if (obs_c[i] - obs_c[i-1] != 3) begin
                n_fail++;
                $display("FAIL gapped_spacing%0d: got %0d cycles, required 3", i, obs_c[i] - obs_c[i-1]);
            end
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 32767);
        clear_obs();
        repeat (11) sample(32767);
        drain();
        n_tests++;
        if (obs_y.size() != 11 || obs_y[0] !== 16'sd16383 || obs_y[10] !== 16'sd32767
            || obs_s[10] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pos: got n=%0d first=%0d last=%0d sat=%0b, required 11 16383 32767 1",
                     obs_y.size(), obs_y[0], obs_y[obs_y.size()-1], obs_s[obs_s.size()-1]);
        end
        clear_obs();
        repeat (11) sample(-32768);
        drain();
        n_tests++;
        if (obs_y.size() != 11 || obs_y[10] !== -16'sd32768 || obs_s[10] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_neg: got n=%0d last=%0d sat=%0b, required 11 -32768 1",
                     obs_y.size(), obs_y[obs_y.size()-1], obs_s[obs_s.size()-1]);
        end
    endtask

    task automatic test_coef_update();
        apply_reset();
        clear_obs();
        sample(32767);
        write_coef(5, 0);       // impulse sits in stage 2 during this write
        write_coef(12, 1234);   // out of range
        repeat (11) sample(0);
        drain();
        n_tests++;
        if (obs_y.size() != 12 || obs_y[5] !== 16'sd5571 || obs_y[4] !== 16'sd4169) begin
            n_fail++;
            $display("FAIL coef_old_value: got n=%0d y4=%0d y5=%0d, required 12 4169 5571",
                     obs_y.size(), obs_y[4], obs_y[5]);
        end
        clear_obs();
        sample(32767);
        repeat (11) sample(0);
        drain();
        n_tests++;
        if (obs_y.size() != 12 || obs_y[5] !== 16'sd0 || obs_y[4] !== 16'sd4169
            || obs_y[1] !== -16'sd198) begin
            n_fail++;
            $display("FAIL coef_new_value: got n=%0d y1=%0d y4=%0d y5=%0d, required 12 -198 4169 0",
                     obs_y.size(), obs_y[1], obs_y[4], obs_y[5]);
        end
    endtask

    task automatic test_flush_primed();
        apply_reset();
        for (int i = 1; i <= 10; i++) sample(i * 100);
        idle(1);
        n_tests++;
        if (o_primed !== 1'b0) begin
            n_fail++;
            $display("FAIL primed_10: got %0b, required 0", o_primed);
        end
        sample(1100);
        idle(1);
        n_tests++;
        if (o_primed !== 1'b1) begin
            n_fail++;
            $display("FAIL primed_11: got %0b, required 1", o_primed);
        end
        drain();
        sample(777, 1'b0);      // will be in stage 2 when flush lands
        @(negedge clk);
        i_flush    = 1'b1;
        i_in_valid = 1'b1;
        i_x        = 16'sd12345;
        @(negedge clk);
        i_flush    = 1'b0;
        i_in_valid = 1'b0;
        model_clear();
        n_tests++;
        if (o_primed !== 1'b0 || o_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_state: got primed=%0b v=%0b, required 0 0", o_primed, o_out_valid);
        end
        idle(3);
        check_impulse("flush_impulse");
    endtask

    task automatic test_reset_midstream();
        write_coef(0, 1000);
        write_coef(5, -5000);
        sample(20000);
        sample(-15000);
        sample(30000);
        drain();
        sample(4321, 1'b0);
        @(negedge clk);
        reset_p     = 1'b1;
        i_in_valid  = 1'b0;
        i_coef_we   = 1'b1;
        i_coef_addr = 4'd0;
        i_coef_data = 16'sd999;
        @(negedge clk);
        n_tests++;
        if (o_out_valid !== 1'b0 || o_y !== 16'sd0 || o_sat !== 1'b0 || o_primed !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: got v=%0b y=%0d sat=%0b primed=%0b, required all 0",
                     o_out_valid, o_y, o_sat, o_primed);
        end
        reset_p   = 1'b0;
        i_coef_we = 1'b0;
        mcoef     = DEF;
        model_clear();
        exp_q.delete();
        idle(2);
        check_impulse("midreset_impulse");
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_gapped();
        test_saturation();
        test_coef_update();
        test_flush_primed();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t, required finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/fir_transposed_stream.md
Name: fir_transposed_stream

Overview:
- 11-tap signed FIR filter in transposed form, with a sample-valid handshake.
- The input sample is broadcast to all taps, and partial sums flow toward the output.
- Runtime-writable coefficient bank; output is rounded and saturated.
- Sits on the same sample stream as the team's systolic FIR. It is the low-latency counterpart: fixed 2-cycle latency regardless of tap count. It is used where the coefficient set changes at runtime.

Parameters:
- NTAPS, 11: number of taps (2..16).
- XW, 16: input sample and output width, signed.
- CW, 16: coefficient width, signed.
- ACCW, 36: internal accumulator width. Must be at least XW+CW+ceil(log2(NTAPS)).
- SHIFT, 16: right-shift applied to the accumulator to form y.

Ports:
- clk, in, 1: rising-edge clock.
- reset_p, in, 1: synchronous active-high reset.
- in_valid, in, 1: x holds a new sample this cycle.
- x, in, XW: signed input sample.
- flush, in, 1: synchronously clears the delay line and the primed count. Coefficients are kept.
- coef_we, in, 1: coefficient write strobe.
- coef_addr, in, 4: tap index to write.
- coef_data, in, CW: signed coefficient value.
- out_valid, out, 1: one-cycle pulse; y is valid.
- y, out, XW: signed filtered output.
- sat, out, 1: y was clipped. Qualified by out_valid.
- primed, out, 1: high once NTAPS samples have been accepted since reset or flush.

Behaviour:
- Interface: one clock domain. Reset is synchronous and active-high on reset_p; clock port clk, reset port reset_p.
- Reset values:
  - out_valid=0, y=0, sat=0, primed=0.
  - x_reg=0, v_reg=0, all partial-sum registers s[1..NTAPS-1]=0, sample count=0.
  - coef[k]=DEFAULT_COEF[k] from the package.
- Stage 1, cycle t: when in_valid=1, x_reg<=x and v_reg<=1; otherwise v_reg<=0. x_reg holds its value when in_valid=0.
- Stage 2, cycle t+1, only when v_reg=1:
  - p[k] = coef[k]*x_reg, signed, sign-extended to ACCW.
  - s[NTAPS-1] <= p[NTAPS-1].
  - s[k] <= s[k+1]+p[k] for k=1..NTAPS-2.
  - acc <= s[1]+p[0].
  - out_valid<=1 in the following cycle (t+2). Latency is exactly 2 cycles from in_valid to out_valid.
- When v_reg=0: s[] and y hold; out_valid<=0. Idle cycles insert no zeros; the filter advances only on valid samples.
- Result: y(n) = sum over k of coef[k]*x(n-k), where n counts accepted samples.
- Output arithmetic, computed from the stage-2 sum:
  - r = (sum + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift (round half up).
  - If r > 2^(XW-1)-1, y = max and sat=1.
  - If r < -2^(XW-1), y = min and sat=1.
  - Otherwise y = r[XW-1:0] and sat=0.
  - y and sat are registered with out_valid and hold until the next out_valid.
- primed:
  - A saturating counter increments on each accepted sample.
  - primed=1 when count >= NTAPS.
  - Before primed, outputs are still produced (zero-history startup response).
- flush:
  - Next cycle: s[]=0, x_reg=0, v_reg=0, count=0, primed=0, out_valid=0.
  - flush has priority over a simultaneous in_valid; that sample is dropped.
  - A sample in stage 2 during the flush cycle is discarded.
- Coefficient write:
  - When coef_we=1 and coef_addr<NTAPS, coef[coef_addr]<=coef_data at the clock edge.
  - coef_addr>=NTAPS is ignored.
  - The new value is used by any stage-2 multiply from the next cycle on.
  - Writing in the same cycle a sample is in stage 2 uses the old value for that sample.
  - The delay line is not cleared by coefficient writes.
- reset_p mid-stream: everything returns to the reset values, including restoring the default coefficients. reset_p overrides flush and coef_we.

Decomposition:
- Package fir_pkg holds DEFAULT_COEF[0..10] = -136, -397, -87, 3004, 8338, 11142, 8338, 3004, -87, -397, -136.
- The package also holds the shared round/saturate function, sized by ACCW, SHIFT and XW.
- One sub-module, fir_tstage: one tap containing the multiply, the add of the upstream partial sum, and the hold-on-invalid register. It is instantiated NTAPS-1 times with a generate loop; the output adder is the top-level tap 0.

Test Plan:
- Impulse, default coefficients: after reset, drive x=32767 for one valid cycle, then x=0 for 11 valid cycles. Required y sequence: -68, -198, -43, 1502, 4169, 5571, 4169, 1502, -43, -198, -68, then 0. out_valid appears 2 cycles after each in_valid; sat=0 throughout.
- Gapped input: same impulse with in_valid every third cycle. The y sequence must be identical, with out_valid pulses spaced 3 cycles apart. No extra pulses.
- Saturation: write all coef=32767, then feed x=32767 for 11 valid samples. y climbs and reaches 32767 with sat=1. Repeat with x=-32768: y=-32768, sat=1.
- Coefficient update: write coef[5]=0 in the same cycle a sample sits in stage 2. That sample uses 11142; the next sample uses 0. Writing coef_addr=12 changes nothing.
- Flush and primed: primed rises on the 11th accepted sample. Assert flush together with in_valid: the sample is dropped, primed=0, out_valid=0 next cycle. A following impulse reproduces the first scenario's sequence.
- Reset mid-stream: after overwriting coefficients, assert reset_p mid-stream. All outputs are 0 the next cycle, and a following impulse gives the default-coefficient sequence.
